// File: rtl/sme_match_collector.sv
// -----------------------------------------------------------------------------
// sme_match_collector
//
// Gathers the rule IDs a string-matching engine reports for one packet and
// emits one report per packet. The matcher presents rule IDs on a
// valid/release interface and signals packet end on a valid/ready handshake.
// After packet end the collector keeps accepting IDs until the match stream
// has been quiet for DRAIN_CYCLES cycles. It then holds a report until the
// consumer takes it. Matches that arrive while no packet is open are kept
// and belong to the next packet.
//
// Ports
//   clk             sole clock, rising edge
//   rst             asynchronous, active-high reset
//   pkt_done_valid  packet-end event from the matcher
//   pkt_done_tag    packet tag, captured on the packet-end handshake
//   pkt_done_ready  collector can take a packet-end event (IDLE only)
//   match_valid     matcher presents a rule ID
//   match_rule_ID   presented rule ID
//   match_release   pops the presented rule ID (low while a report is pending)
//   out_valid       per-packet report valid
//   out_ready       report consumed
//   out_tag         tag of the reported packet
//   out_count       matches accepted for the packet, saturating at 255
//   out_overflow    more than MAX_MATCHES matches were accepted
//   out_ids         stored rule IDs, slot k at [k*ID_WIDTH +: ID_WIDTH]
//   stat_pkt_cnt    reports delivered (wrapping)
//   stat_drop_cnt   matches accepted but not stored (wrapping)
// -----------------------------------------------------------------------------
module sme_match_collector #(
   parameter int MAX_MATCHES  = 8,
   parameter int DRAIN_CYCLES = 16,
   parameter int ID_WIDTH     = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            pkt_done_valid,
   input  logic [7:0]                      pkt_done_tag,
   output logic                            pkt_done_ready,
   input  logic                            match_valid,
   input  logic [ID_WIDTH-1:0]             match_rule_ID,
   output logic                            match_release,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [7:0]                      out_tag,
   output logic [7:0]                      out_count,
   output logic                            out_overflow,
   output logic [MAX_MATCHES*ID_WIDTH-1:0] out_ids,
   output logic [31:0]                     stat_pkt_cnt,
   output logic [31:0]                     stat_drop_cnt
);

   // Drain counter wide enough to hold DRAIN_CYCLES (at least one bit).
   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] LP_DRAIN = DW'(DRAIN_CYCLES);
   localparam logic [31:0]   LP_MAX   = 32'(MAX_MATCHES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t              r_state;
   logic [7:0]          r_tag;
   logic [7:0]          r_count;
   logic                r_overflow;
   logic [DW-1:0]       r_drain;
   logic [31:0]         r_stat_pkt;
   logic [31:0]         r_stat_drop;
   logic [ID_WIDTH-1:0] r_slots [MAX_MATCHES];

   logic w_in_report;
   logic w_accept;
   logic w_done_hs;
   logic w_has_room;

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   assign w_in_report = (r_state == REPORT);

   // Both handshakes are also gated by rst so nothing is offered to the
   // neighbours while the block is held in reset.
   assign pkt_done_ready = (r_state == IDLE) & ~rst;
   assign match_release  = match_valid & ~w_in_report & ~rst;

   assign w_accept   = match_valid & match_release;
   assign w_done_hs  = pkt_done_valid & pkt_done_ready;

   // Count saturates at 255, so the slot check is done in 32 bits to stay
   // correct for any MAX_MATCHES.
   assign w_has_room = ({24'd0, r_count} < LP_MAX);

   // ---------------------------------------------------------------------------
   // Control FSM and report datapath
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others regardless of the
   // order the statements are written in below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tag       <= 8'd0;
         r_count     <= 8'd0;
         r_overflow  <= 1'b0;
         r_drain     <= '0;
         r_stat_pkt  <= 32'd0;
         r_stat_drop <= 32'd0;
         // NOTE: the slot array is part of the visible report (unused slots
         // must read 0), so unlike a plain storage RAM it is reset.
         for (int k = 0; k < MAX_MATCHES; k++) begin
            r_slots[k] <= '0;
         end
      end else begin
         // Match bookkeeping. w_accept can only be high in IDLE or COLLECT;
         // in IDLE the match is credited to the packet that comes next.
         if (w_accept) begin
            if (r_count != 8'hFF) begin
               r_count <= r_count + 8'd1;
            end
            if (w_has_room) begin
               for (int k = 0; k < MAX_MATCHES; k++) begin
                  if ({24'd0, r_count} == 32'(k)) begin
                     r_slots[k] <= match_rule_ID;
                  end
               end
            end else begin
               r_overflow  <= 1'b1;
               r_stat_drop <= r_stat_drop + 32'd1;
            end
         end

         case (r_state)
            IDLE: begin
               if (w_done_hs) begin
                  r_tag   <= pkt_done_tag;
                  r_drain <= LP_DRAIN;
                  r_state <= COLLECT;
               end
            end

            COLLECT: begin
               // Every accepted match restarts the quiet window. The report
               // opens on the edge at which the counter would reach 0, so
               // out_valid rises DRAIN_CYCLES+1 cycles after the last event.
               if (w_accept) begin
                  r_drain <= LP_DRAIN;
               end else if (r_drain <= DW'(1)) begin
                  r_drain <= '0;
                  r_state <= REPORT;
               end else begin
                  r_drain <= r_drain - DW'(1);
               end
            end

            REPORT: begin
               // The report is held unchanged until taken. Taking it clears
               // the accumulator on the same edge so the next packet starts
               // clean.
               if (out_ready) begin
                  r_state    <= IDLE;
                  r_stat_pkt <= r_stat_pkt + 32'd1;
                  r_count    <= 8'd0;
                  r_overflow <= 1'b0;
                  for (int k = 0; k < MAX_MATCHES; k++) begin
                     r_slots[k] <= '0;
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output mapping
   // ---------------------------------------------------------------------------
   assign out_valid     = w_in_report;
   assign out_tag       = r_tag;
   assign out_count     = r_count;
   assign out_overflow  = r_overflow;
   assign stat_pkt_cnt  = r_stat_pkt;
   assign stat_drop_cnt = r_stat_drop;

   // NOTE: the default assignment first guarantees every bit is written on
   // every evaluation, so no latch can be inferred from this block.
   always_comb begin
      out_ids = '0;
      for (int k = 0; k < MAX_MATCHES; k++) begin
         out_ids[k*ID_WIDTH +: ID_WIDTH] = r_slots[k];
      end
   end

endmodule

// File: tb/tb_sme_match_collector.sv
// -----------------------------------------------------------------------------
// tb_sme_match_collector
//
// Directed scenarios plus randomized traffic for sme_match_collector.
// The reference model works at the transaction level. It keeps a queue of
// accepted rule IDs and the cycle number of the last event that opens or
// extends the quiet window. The report is expected to become visible exactly
// DRAIN_CYCLES+1 cycles after that event.
// -----------------------------------------------------------------------------
module tb_sme_match_collector;

   localparam int D   = 16;
   localparam int MAX = 8;
   localparam int IDW = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 pkt_done_valid;
   logic [7:0]           pkt_done_tag;
   logic                 pkt_done_ready;
   logic                 match_valid;
   logic [IDW-1:0]       match_rule_ID;
   logic                 match_release;
   logic                 out_valid;
   logic                 out_ready;
   logic [7:0]           out_tag;
   logic [7:0]           out_count;
   logic                 out_overflow;
   logic [MAX*IDW-1:0]   out_ids;
   logic [31:0]          stat_pkt_cnt;
   logic [31:0]          stat_drop_cnt;

   sme_match_collector #(
      .MAX_MATCHES  (MAX),
      .DRAIN_CYCLES (D),
      .ID_WIDTH     (IDW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pkt_done_valid (pkt_done_valid),
      .pkt_done_tag   (pkt_done_tag),
      .pkt_done_ready (pkt_done_ready),
      .match_valid    (match_valid),
      .match_rule_ID  (match_rule_ID),
      .match_release  (match_release),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_tag        (out_tag),
      .out_count      (out_count),
      .out_overflow   (out_overflow),
      .out_ids        (out_ids),
      .stat_pkt_cnt   (stat_pkt_cnt),
      .stat_drop_cnt  (stat_drop_cnt)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, last_cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [IDW-1:0] m_q[$];     // stored IDs of the open accumulator
   int unsigned    m_n;        // accepted matches (unsaturated)
   bit             m_have;     // a packet end has been taken, report pending
   logic [7:0]     m_tag;
   int             m_last;     // cycle of handshake or latest match after it
   int unsigned    m_pkts;
   int unsigned    m_drops;

   int cyc      = 0;
   int last_cyc = 0;

   task automatic model_reset();
      m_q.delete();
      m_n     = 0;
      m_have  = 0;
      m_tag   = 8'd0;
      m_last  = 0;
      m_pkts  = 0;
      m_drops = 0;
   endtask

   function automatic logic [127:0] model_ids();
      logic [127:0] v = '0;
      for (int k = 0; k < m_q.size(); k++) v[k*IDW +: IDW] = m_q[k];
      return v;
   endfunction

   // One clock cycle: drive inputs after the edge, sample mid-cycle, compare
   // against the model, then advance the model with this cycle's events.
   task automatic tick(input bit r, input bit pv, input logic [7:0] pt,
                       input bit mv, input logic [IDW-1:0] mid, input bit ordy);
      bit exp_rep;
      bit acc;
      bit hs;
      @(posedge clk);
      #1;
      rst            = r;
      pkt_done_valid = pv;
      pkt_done_tag   = pt;
      match_valid    = mv;
      match_rule_ID  = mid;
      out_ready      = ordy;
      #1;
      last_cyc = cyc;
      cyc++;
      if (r) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_match_release", match_release, 0);
         model_reset();
         return;
      end
      exp_rep = m_have && (last_cyc >= m_last + D + 1);
      check("pkt_done_ready", pkt_done_ready, !m_have);
      check("match_release", match_release, mv && !exp_rep);
      check("out_valid", out_valid, exp_rep);
      check("out_count", out_count, (m_n > 255) ? 255 : m_n);
      check("out_overflow", out_overflow, m_n > MAX);
      check("out_ids", out_ids, model_ids());
      check("stat_pkt_cnt", stat_pkt_cnt, m_pkts);
      check("stat_drop_cnt", stat_drop_cnt, m_drops);
      if (m_have) check("out_tag", out_tag, m_tag);

      acc = mv && !exp_rep;
      hs  = pv && !m_have;
      if (acc) begin
         if (m_q.size() < MAX) m_q.push_back(mid);
         else m_drops++;
         m_n++;
         if (m_have) m_last = last_cyc;
      end
      if (hs) begin
         m_have = 1;
         m_tag  = pt;
         m_last = last_cyc;
      end
      if (exp_rep && ordy) begin
         m_pkts++;
         m_q.delete();
         m_n    = 0;
         m_have = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0, '0, 0);
   endtask

   // Runs quiet cycles until out_valid is seen; lat is the distance from
   // start_cyc, or -1 if the bound expires.
   task automatic wait_report(input bit ordy, input int start_cyc, output int lat);
      lat = -1;
      for (int i = 0; i < 60; i++) begin
         tick(0, 0, 8'h00, 0, '0, ordy);
         if (out_valid === 1'b1) begin
            lat = last_cyc - start_cyc;
            break;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat;
      int           hs_c;
      int           last_m;
      bit           rel_seen;
      bit           unstable;
      logic [127:0] exp_v;

      rst            = 1'b1;
      pkt_done_valid = 1'b0;
      pkt_done_tag   = 8'h00;
      match_valid    = 1'b0;
      match_rule_ID  = '0;
      out_ready      = 1'b0;
      model_reset();

      // Reset state, with a match offered during reset.
      tick(1, 0, 8'h00, 1, 16'hAAAA, 0);
      tick(1, 0, 8'h00, 1, 16'hAAAA, 0);
      tick(0, 0, 8'h00, 0, '0, 0);
      check("reset_tag", out_tag, 0);
      check("reset_count", out_count, 0);
      check("reset_ids", out_ids, 0);
      check("reset_ready", pkt_done_ready, 1);

      // Tag 0x05, no matches, consumer always ready.
      tick(0, 1, 8'h05, 0, '0, 1);
      hs_c = last_cyc;
      wait_report(1, hs_c, lat);
      check("t1_latency", lat, D + 1);
      check("t1_tag", out_tag, 8'h05);
      check("t1_count", out_count, 0);
      check("t1_ids", out_ids, 0);
      tick(0, 0, 8'h00, 0, '0, 0);
      check("t1_stat_pkt", stat_pkt_cnt, 1);
      check("t1_out_valid_drop", out_valid, 0);

      // Tag 0x07, three IDs four cycles apart.
      tick(0, 1, 8'h07, 0, '0, 0);
      idle(3); tick(0, 0, 8'h00, 1, 16'h0011, 0);
      idle(3); tick(0, 0, 8'h00, 1, 16'h0022, 0);
      idle(3); tick(0, 0, 8'h00, 1, 16'h0033, 0);
      last_m = last_cyc;
      wait_report(1, last_m, lat);
      check("t2_latency", lat, D + 1);
      check("t2_tag", out_tag, 8'h07);
      check("t2_count", out_count, 3);
      check("t2_ids", out_ids, {80'd0, 16'h0033, 16'h0022, 16'h0011});

      // Ten back-to-back matches: two dropped.
      tick(0, 1, 8'h09, 0, '0, 0);
      exp_v = '0;
      for (int i = 0; i < 10; i++) begin
         tick(0, 0, 8'h00, 1, 16'h0A00 + 16'(i), 0);
         if (i < MAX) exp_v[i*IDW +: IDW] = 16'h0A00 + 16'(i);
      end
      wait_report(1, last_cyc, lat);
      check("t3_latency", lat, D + 1);
      check("t3_count", out_count, 10);
      check("t3_overflow", out_overflow, 1);
      check("t3_ids", out_ids, exp_v);
      check("t3_drops", stat_drop_cnt, 2);

      // Report held 20 cycles with a match waiting.
      tick(0, 1, 8'h38, 0, '0, 0);
      tick(0, 0, 8'h00, 1, 16'h0038, 0);
      wait_report(0, last_cyc, lat);
      check("t4_latency", lat, D + 1);
      rel_seen = 0;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         tick(0, 0, 8'h00, 1, 16'hBEEF, 0);
         if (match_release !== 1'b0) rel_seen = 1;
         if (out_valid !== 1'b1 || out_count !== 8'd1 || out_tag !== 8'h38 ||
             out_ids !== {112'd0, 16'h0038}) unstable = 1;
      end
      check("t4_no_release", rel_seen, 0);
      check("t4_stable", unstable, 0);
      tick(0, 0, 8'h00, 1, 16'hBEEF, 1);
      tick(0, 0, 8'h00, 1, 16'hBEEF, 0);
      check("t4_release_after", match_release, 1);
      tick(0, 0, 8'h00, 0, '0, 0);
      check("t4_pending_count", out_count, 1);
      check("t4_pending_id", out_ids, {112'd0, 16'hBEEF});
      tick(0, 1, 8'h40, 0, '0, 0);
      wait_report(1, last_cyc, lat);
      check("t4b_latency", lat, D + 1);
      check("t4b_ids", out_ids, {112'd0, 16'hBEEF});

      // Same-cycle packet end and match in IDLE.
      tick(0, 1, 8'h39, 1, 16'h0100, 0);
      wait_report(1, last_cyc, lat);
      check("t5_latency", lat, D + 1);
      check("t5_count", out_count, 1);
      check("t5_ids", out_ids, {112'd0, 16'h0100});

      // Count saturation at 255.
      tick(0, 1, 8'h55, 0, '0, 0);
      for (int i = 0; i < 260; i++) tick(0, 0, 8'h00, 1, 16'(i), 0);
      wait_report(1, last_cyc, lat);
      check("t_sat_count", out_count, 255);
      check("t_sat_overflow", out_overflow, 1);

      // Reset five cycles into COLLECT.
      tick(0, 1, 8'h40, 0, '0, 0);
      tick(0, 0, 8'h00, 1, 16'h1234, 0);
      idle(4);
      tick(1, 0, 8'h00, 1, 16'h1234, 1);
      tick(1, 0, 8'h00, 0, '0, 1);
      tick(0, 0, 8'h00, 0, '0, 1);
      check("t6_out_valid", out_valid, 0);
      check("t6_ready", pkt_done_ready, 1);
      check("t6_count", out_count, 0);
      check("t6_overflow", out_overflow, 0);
      check("t6_ids", out_ids, 0);
      check("t6_tag", out_tag, 0);
      check("t6_stat_pkt", stat_pkt_cnt, 0);
      check("t6_stat_drop", stat_drop_cnt, 0);
      rel_seen = 0;
      for (int i = 0; i < 25; i++) begin
         tick(0, 0, 8'h00, 0, '0, 1);
         if (out_valid !== 1'b0) rel_seen = 1;
      end
      check("t6_no_report", rel_seen, 0);

      // Randomized traffic with varying match density.
      for (int seg = 0; seg < 8; seg++) begin
         for (int i = 0; i < 250; i++) begin
            tick(0,
                 ($urandom % 12) == 0,
                 8'($urandom),
                 ($urandom % (3 + seg * 6)) == 0,
                 16'($urandom),
                 ($urandom % 2) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sme_match_collector.md
SME_MATCH_COLLECTOR -- requirements
Module: sme_match_collector

Interface
REQ-001 SHALL have parameter MAX_MATCHES, default 8: rule-ID slots stored per packet.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 16: idle cycles after packet end before the report is closed.
REQ-003 SHALL have parameter ID_WIDTH, default 16: rule-ID width.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port pkt_done_valid, input, 1: last input beat of a packet has been accepted by the matcher.
REQ-007 SHALL have port pkt_done_tag, input, 8: packet tag, sampled on the pkt_done handshake.
REQ-008 SHALL have port pkt_done_ready, output, 1: collector can accept a packet-end event.
REQ-009 SHALL have port match_valid, input, 1: matcher presents a rule ID.
REQ-010 SHALL have port match_rule_ID, input, ID_WIDTH: presented rule ID.
REQ-011 SHALL have port match_release, output, 1: pops the presented rule ID.
REQ-012 SHALL have port out_valid, output, 1: per-packet report valid.
REQ-013 SHALL have port out_ready, input, 1: report consumed.
REQ-014 SHALL have port out_tag, output, 8: tag of the reported packet.
REQ-015 SHALL have port out_count, output, 8: matches accepted for the packet, saturating at 255.
REQ-016 SHALL have port out_overflow, output, 1: more than MAX_MATCHES matches were accepted.
REQ-017 SHALL have port out_ids, output, MAX_MATCHES*ID_WIDTH: slot k at bits [k*ID_WIDTH +: ID_WIDTH]; unused slots are 0.
REQ-018 SHALL have port stat_pkt_cnt, output, 32: reports delivered, wrapping.
REQ-019 SHALL have port stat_drop_cnt, output, 32: matches accepted but not stored, wrapping.

Function
REQ-020 SHALL implement three states: IDLE, COLLECT and REPORT.
REQ-021 SHALL drive pkt_done_ready = 1 only in IDLE; a pkt_done handshake latches the tag and moves IDLE to COLLECT.
REQ-022 SHALL drive match_release = match_valid in IDLE and COLLECT, and 0 in REPORT; matches stall during REPORT.
REQ-023 SHALL treat a match as accepted in a cycle with match_valid=1 and match_release=1; matches accepted in IDLE belong to the next packet.
REQ-024 SHALL, on an accepted match with count < MAX_MATCHES, write the ID into slot[count]; otherwise set overflow (sticky) and increment stat_drop_cnt.
REQ-025 SHALL increment count on every accepted match, saturating at 255.
REQ-026 SHALL load the drain counter with DRAIN_CYCLES on entry to COLLECT and on every accepted match while in COLLECT, and decrement it otherwise.
REQ-027 SHALL move COLLECT to REPORT on the edge at which the drain counter reaches 0, i.e. after DRAIN_CYCLES consecutive match-free COLLECT cycles; with no matches, out_valid is first high DRAIN_CYCLES+1 cycles after the handshake cycle.
REQ-028 SHALL, if a match and the pkt_done handshake occur in the same IDLE cycle, store the match and enter COLLECT with the drain counter at DRAIN_CYCLES.
REQ-029 SHALL assert out_valid only in REPORT, holding out_tag, out_count, out_overflow and out_ids stable until out_ready.
REQ-030 SHALL, on out_valid & out_ready, return to IDLE, increment stat_pkt_cnt, and clear count, overflow and all slots to 0 on the same edge.
REQ-031 SHALL accept out_ready=1 in the first REPORT cycle, giving a one-cycle report.
REQ-032 SHALL keep pkt_done_ready low in REPORT and COLLECT, so a packet-end event never overwrites the current tag.

Reset
REQ-033 SHALL, on rst=1, immediately enter IDLE and clear count, overflow, slots, tag, drain counter, stat_pkt_cnt and stat_drop_cnt to 0; out_valid=0 and match_release=0 while rst is high.
REQ-034 SHALL, on rst mid-COLLECT or mid-REPORT, discard the report without it ever appearing on out_valid.

Verification
REQ-035 SHALL test: pkt_done tag 0x05, no matches, out_ready=1 -> out_valid high exactly 17 cycles after the handshake, count 0, ids all 0, stat_pkt_cnt 1.
REQ-036 SHALL test: IDs 0x0011, 0x0022, 0x0033 every 4 cycles after pkt_done tag 0x07 -> report count 3, slots 0-2 = 0x0011/0x0022/0x0033, out_valid 17 cycles after the last match.
REQ-037 SHALL test: 10 back-to-back matches -> count 10, overflow 1, slots hold the first 8 IDs, stat_drop_cnt 2.
REQ-038 SHALL test: out_ready held low 20 cycles with match_valid=1 -> match_release 0 throughout, outputs stable; the pending match is counted into the next packet after out_ready.
REQ-039 SHALL test: same-cycle pkt_done and match (ID 0x0100) in IDLE -> report contains 0x0100, count 1.
REQ-040 SHALL test: rst asserted 5 cycles into COLLECT -> no out_valid, all outputs 0, pkt_done_ready 1 after release.
